// File: rtl/frame_source_arbiter.sv
// frame_source_arbiter: packet-granular round-robin arbiter sharing one
// frame-forming datapath between NUM_SRC AXI-Stream requesters.
// A grant is held for a whole frame and released only after the tlast
// handshake. The header configuration of the winner is latched at grant time.
// Optional feature: define FRAME_ARB_STATS_EN to add per-source 16-bit
// frame counters on output Frame_Count.
module frame_source_arbiter #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                       ACLK,
    input  logic                       ARESETN,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] S_AXIS_tdata,
    input  logic [NUM_SRC*8-1:0]       S_AXIS_tkeep,
    input  logic [NUM_SRC-1:0]         S_AXIS_tvalid,
    input  logic [NUM_SRC-1:0]         S_AXIS_tlast,
    output logic [NUM_SRC-1:0]         S_AXIS_tready,
    input  logic [NUM_SRC*48-1:0]      Cfg_Destination_Address,
    input  logic [NUM_SRC*48-1:0]      Cfg_Source_Address,
    input  logic [NUM_SRC*16-1:0]      Cfg_Link_Type,
    input  logic [NUM_SRC*16-1:0]      Cfg_SyncWord,
    input  logic [NUM_SRC*14-1:0]      Cfg_Packet_Size,
    output logic [DATA_WIDTH-1:0]      M_AXIS_tdata,
    output logic [7:0]                 M_AXIS_tkeep,
    output logic                       M_AXIS_tvalid,
    output logic                       M_AXIS_tlast,
    input  logic                       M_AXIS_tready,
    output logic [47:0]                Destination_Address,
    output logic [47:0]                Source_Address,
    output logic [15:0]                Link_Type,
    output logic [15:0]                SyncWord,
    output logic [13:0]                Packet_Size,
    output logic [NUM_SRC-1:0]         Grant,
    output logic                       Frame_Active
`ifdef FRAME_ARB_STATS_EN
    ,
    output logic [NUM_SRC*16-1:0]      Frame_Count
`endif
);

    localparam int unsigned KEEP_W  = 8;
    localparam int unsigned MAC_W   = 48;
    localparam int unsigned TYPE_W  = 16;
    localparam int unsigned SYNC_W  = 16;
    localparam int unsigned SIZE_W  = 14;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned PTR_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand_idx;
    logic               win_found;
    logic               beat_done;

    logic [DATA_WIDTH-1:0] src_data [NUM_SRC];
    logic [KEEP_W-1:0]     src_keep [NUM_SRC];
    logic [MAC_W-1:0]      src_da   [NUM_SRC];
    logic [MAC_W-1:0]      src_sa   [NUM_SRC];
    logic [TYPE_W-1:0]     src_lt   [NUM_SRC];
    logic [SYNC_W-1:0]     src_sw   [NUM_SRC];
    logic [SIZE_W-1:0]     src_ps   [NUM_SRC];

    // Unpack the per-source slices into arrays indexed by source number
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_data[i] = S_AXIS_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign src_keep[i] = S_AXIS_tkeep[i*KEEP_W +: KEEP_W];
        assign src_da[i]   = Cfg_Destination_Address[i*MAC_W +: MAC_W];
        assign src_sa[i]   = Cfg_Source_Address[i*MAC_W +: MAC_W];
        assign src_lt[i]   = Cfg_Link_Type[i*TYPE_W +: TYPE_W];
        assign src_sw[i]   = Cfg_SyncWord[i*SYNC_W +: SYNC_W];
        assign src_ps[i]   = Cfg_Packet_Size[i*SIZE_W +: SIZE_W];
    end

    // Round-robin search: first requester at or above rr_ptr, with wrap
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            cand_idx = PTR_W'((32'(rr_ptr) + k) % NUM_SRC);
            if (!win_found && S_AXIS_tvalid[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Next-state and combinational datapath mux toward the frame former
    always_comb begin
        state_next    = state;
        M_AXIS_tdata  = '0;
        M_AXIS_tkeep  = '0;
        M_AXIS_tvalid = 1'b0;
        M_AXIS_tlast  = 1'b0;
        S_AXIS_tready = '0;
        beat_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_found) begin
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                M_AXIS_tdata           = src_data[gnt_idx];
                M_AXIS_tkeep           = src_keep[gnt_idx];
                M_AXIS_tvalid          = S_AXIS_tvalid[gnt_idx];
                M_AXIS_tlast           = S_AXIS_tlast[gnt_idx];
                S_AXIS_tready[gnt_idx] = M_AXIS_tready;
                beat_done = S_AXIS_tvalid[gnt_idx] & M_AXIS_tready & S_AXIS_tlast[gnt_idx];
                if (beat_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, grant, pointer and header latches
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state               <= ST_IDLE;
            rr_ptr              <= '0;
            gnt_idx             <= '0;
            Grant               <= '0;
            Frame_Active        <= 1'b0;
            Destination_Address <= '0;
            Source_Address      <= '0;
            Link_Type           <= '0;
            SyncWord            <= '0;
            Packet_Size         <= '0;
        end else begin
            state        <= state_next;
            Frame_Active <= (state_next == ST_BUSY);
            if ((state == ST_IDLE) && win_found) begin
                gnt_idx             <= win_idx;
                Grant               <= NUM_SRC'(1) << win_idx;
                Destination_Address <= src_da[win_idx];
                Source_Address      <= src_sa[win_idx];
                Link_Type           <= src_lt[win_idx];
                SyncWord            <= src_sw[win_idx];
                Packet_Size         <= src_ps[win_idx];
            end
            if (beat_done) begin
                Grant  <= '0;
                rr_ptr <= (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;
            end
        end
    end

`ifdef FRAME_ARB_STATS_EN
    logic [CNT_W-1:0] frame_cnt [NUM_SRC];

    // Per-source completed-frame counters, wrapping at 16 bits
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                frame_cnt[i] <= '0;
            end
        end else if (beat_done) begin
            frame_cnt[gnt_idx] <= frame_cnt[gnt_idx] + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_cnt_pack
        assign Frame_Count[i*CNT_W +: CNT_W] = frame_cnt[i];
    end
`endif

endmodule

// File: tb/tb_frame_source_arbiter.sv
// Testbench for frame_source_arbiter: randomized sources and sink readiness,
// a transaction-level reference model, and a scoreboard monitor.
module tb_frame_source_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 64;

    typedef struct {
        logic [DW-1:0] data;
        logic [7:0]    keep;
        logic          last;
    } beat_t;

    typedef struct {
        int            src;
        logic [DW-1:0] data;
        logic [7:0]    keep;
        logic          last;
    } exp_t;

    logic              ACLK;
    logic              ARESETN;
    logic [N*DW-1:0]   S_AXIS_tdata;
    logic [N*8-1:0]    S_AXIS_tkeep;
    logic [N-1:0]      S_AXIS_tvalid;
    logic [N-1:0]      S_AXIS_tlast;
    logic [N-1:0]      S_AXIS_tready;
    logic [N*48-1:0]   Cfg_Destination_Address;
    logic [N*48-1:0]   Cfg_Source_Address;
    logic [N*16-1:0]   Cfg_Link_Type;
    logic [N*16-1:0]   Cfg_SyncWord;
    logic [N*14-1:0]   Cfg_Packet_Size;
    logic [DW-1:0]     M_AXIS_tdata;
    logic [7:0]        M_AXIS_tkeep;
    logic              M_AXIS_tvalid;
    logic              M_AXIS_tlast;
    logic              M_AXIS_tready;
    logic [47:0]       Destination_Address;
    logic [47:0]       Source_Address;
    logic [15:0]       Link_Type;
    logic [15:0]       SyncWord;
    logic [13:0]       Packet_Size;
    logic [N-1:0]      Grant;
    logic              Frame_Active;
`ifdef FRAME_ARB_STATS_EN
    logic [N*16-1:0]   Frame_Count;
`endif

    // Source-side drive state
    logic [DW-1:0] s_data [N];
    logic [7:0]    s_keep [N];
    logic [N-1:0]  tv;
    logic [N-1:0]  s_last;
    logic [47:0]   cfg_da [N];
    logic [47:0]   cfg_sa [N];
    logic [15:0]   cfg_lt [N];
    logic [15:0]   cfg_sw [N];
    logic [13:0]   cfg_ps [N];

    for (genvar i = 0; i < N; i++) begin : g_pack
        assign S_AXIS_tdata[i*DW +: DW]           = s_data[i];
        assign S_AXIS_tkeep[i*8 +: 8]             = s_keep[i];
        assign Cfg_Destination_Address[i*48 +: 48] = cfg_da[i];
        assign Cfg_Source_Address[i*48 +: 48]     = cfg_sa[i];
        assign Cfg_Link_Type[i*16 +: 16]          = cfg_lt[i];
        assign Cfg_SyncWord[i*16 +: 16]           = cfg_sw[i];
        assign Cfg_Packet_Size[i*14 +: 14]        = cfg_ps[i];
    end
    assign S_AXIS_tvalid = tv;
    assign S_AXIS_tlast  = s_last;

    frame_source_arbiter #(.NUM_SRC(N), .DATA_WIDTH(DW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tkeep(S_AXIS_tkeep),
        .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tlast(S_AXIS_tlast),
        .S_AXIS_tready(S_AXIS_tready),
        .Cfg_Destination_Address(Cfg_Destination_Address),
        .Cfg_Source_Address(Cfg_Source_Address),
        .Cfg_Link_Type(Cfg_Link_Type), .Cfg_SyncWord(Cfg_SyncWord),
        .Cfg_Packet_Size(Cfg_Packet_Size),
        .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tkeep(M_AXIS_tkeep),
        .M_AXIS_tvalid(M_AXIS_tvalid), .M_AXIS_tlast(M_AXIS_tlast),
        .M_AXIS_tready(M_AXIS_tready),
        .Destination_Address(Destination_Address), .Source_Address(Source_Address),
        .Link_Type(Link_Type), .SyncWord(SyncWord), .Packet_Size(Packet_Size),
        .Grant(Grant), .Frame_Active(Frame_Active)
`ifdef FRAME_ARB_STATS_EN
        , .Frame_Count(Frame_Count)
`endif
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;

    // Frame queues: what each source still has to send, and the model copy
    beat_t src_q [N][$];
    beat_t mdl_q [N][$];
    exp_t  exp_q [$];
    int    fid   [N];

    // Reference model state: arbiter seen as a frame-level round robin
    logic        m_busy = 1'b0;
    int          m_src  = 0;
    int          m_ptr  = 0;
    int          m_left = 0;
    logic [47:0] m_da = '0, m_sa = '0;
    logic [15:0] m_lt = '0, m_sw = '0;
    logic [13:0] m_ps = '0;
    logic [15:0] m_cnt [N];

    // Phase knobs
    logic [N-1:0] gen_mask = '0;
    int gen_pct = 0, len_min = 1, len_max = 1, vld_pct = 100, rdy_pct = 100, cfg_pct = 0;
    logic do_rst = 1'b1;
    logic mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic rand_cfg(input int i);
        cfg_da[i] = 48'({$urandom(), $urandom()});
        cfg_sa[i] = 48'({$urandom(), $urandom()});
        cfg_lt[i] = 16'($urandom());
        cfg_sw[i] = 16'($urandom());
        cfg_ps[i] = 14'($urandom());
    endtask

    // Model: one decision per clock edge from the inputs sampled at that edge
    task automatic model_update(input logic [N-1:0] ctv, input logic crdy, input logic crst);
        beat_t b;
        exp_t  e;
        int    w;
        if (!crst) begin
            m_busy = 1'b0; m_ptr = 0; m_left = 0;
            m_da = '0; m_sa = '0; m_lt = '0; m_sw = '0; m_ps = '0;
            exp_q.delete();
            for (int i = 0; i < N; i++) m_cnt[i] = '0;
        end else if (!m_busy) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && ctv[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            if (w >= 0) begin
                m_busy = 1'b1; m_src = w; m_left = 0;
                m_da = cfg_da[w]; m_sa = cfg_sa[w]; m_lt = cfg_lt[w];
                m_sw = cfg_sw[w]; m_ps = cfg_ps[w];
                b.last = 1'b0;
                while (!b.last && mdl_q[w].size() > 0) begin
                    b = mdl_q[w].pop_front();
                    e.src = w; e.data = b.data; e.keep = b.keep; e.last = b.last;
                    exp_q.push_back(e);
                    m_left++;
                end
            end
        end else if (ctv[m_src] && crdy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_ptr  = (m_src + 1) % N;
                m_cnt[m_src] = m_cnt[m_src] + 16'd1;
            end
        end
    endtask

    // One clock of stimulus: sample at negedge, update model and drive after posedge
    task automatic step();
        logic [N-1:0] hs, ctv;
        logic crdy, crst;
        beat_t b;
        int len;
        @(negedge ACLK);
        hs   = S_AXIS_tvalid & S_AXIS_tready;
        ctv  = S_AXIS_tvalid;
        crdy = M_AXIS_tready;
        crst = ARESETN;
        @(posedge ACLK);
        #1;
        model_update(ctv, crdy, crst);
        for (int i = 0; i < N; i++) begin
            if (hs[i] && src_q[i].size() > 0) begin
                b = src_q[i].pop_front();
                tv[i] = 1'b0;
            end
        end
        if (do_rst) begin
            ARESETN = 1'b0;
            tv = '0;
            s_last = '0;
            for (int i = 0; i < N; i++) begin
                src_q[i].delete();
                mdl_q[i].delete();
            end
        end else begin
            ARESETN = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (gen_mask[i] && src_q[i].size() == 0 && $urandom_range(99) < gen_pct) begin
                    len = $urandom_range(len_max, len_min);
                    for (int k = 0; k < len; k++) begin
                        b.data = {8'(i), 16'(fid[i]), 8'(k), $urandom()};
                        b.keep = 8'($urandom());
                        b.last = (k == len - 1);
                        src_q[i].push_back(b);
                        mdl_q[i].push_back(b);
                    end
                    fid[i]++;
                end
                if (src_q[i].size() > 0) begin
                    if (!tv[i]) tv[i] = ($urandom_range(99) < vld_pct);
                    s_data[i] = src_q[i][0].data;
                    s_keep[i] = src_q[i][0].keep;
                    s_last[i] = src_q[i][0].last;
                end else begin
                    tv[i]     = 1'b0;
                    s_last[i] = 1'b0;
                    s_data[i] = {$urandom(), $urandom()};
                    s_keep[i] = 8'($urandom());
                end
                if ($urandom_range(99) < cfg_pct) rand_cfg(i);
            end
            M_AXIS_tready = ($urandom_range(99) < rdy_pct);
        end
    endtask

    task automatic run(input int cyc, input logic [N-1:0] mask, input int gp, input int lmin,
                       input int lmax, input int vp, input int rp, input int cp);
        gen_mask = mask; gen_pct = gp; len_min = lmin; len_max = lmax;
        vld_pct = vp; rdy_pct = rp; cfg_pct = cp;
        repeat (cyc) step();
    endtask

    // Scoreboard monitor: per-cycle control checks and per-beat payload checks
    exp_t         e_mon;
    logic [N-1:0] eg, er;
    always @(negedge ACLK) begin
        if (mon_en) begin
            eg = m_busy ? (N'(1) << m_src) : '0;
            er = (m_busy && M_AXIS_tready) ? (N'(1) << m_src) : '0;
            check("grant", 64'(Grant), 64'(eg));
            check("frame_active", 64'(Frame_Active), 64'(m_busy));
            check("s_tready", 64'(S_AXIS_tready), 64'(er));
            check("m_tvalid", 64'(M_AXIS_tvalid), 64'(m_busy & tv[m_src]));
            check("hdr_dst", 64'(Destination_Address), 64'(m_da));
            check("hdr_src", 64'(Source_Address), 64'(m_sa));
            check("hdr_type", 64'(Link_Type), 64'(m_lt));
            check("hdr_sync", 64'(SyncWord), 64'(m_sw));
            check("hdr_size", 64'(Packet_Size), 64'(m_ps));
            if (!m_busy) begin
                check("idle_tdata", M_AXIS_tdata, 64'(0));
                check("idle_tkeep", 64'(M_AXIS_tkeep), 64'(0));
                check("idle_tlast", 64'(M_AXIS_tlast), 64'(0));
            end
`ifdef FRAME_ARB_STATS_EN
            for (int i = 0; i < N; i++) begin
                check("frame_count", 64'(Frame_Count[i*16 +: 16]), 64'(m_cnt[i]));
            end
`endif
            if (M_AXIS_tvalid === 1'b1 && M_AXIS_tready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%h required=none at %0t", M_AXIS_tdata, $time);
                end else begin
                    e_mon = exp_q.pop_front();
                    check("beat_data", M_AXIS_tdata, e_mon.data);
                    check("beat_keep", 64'(M_AXIS_tkeep), 64'(e_mon.keep));
                    check("beat_last", 64'(M_AXIS_tlast), 64'(e_mon.last));
                    check("beat_grant", 64'(Grant), 64'(N'(1) << e_mon.src));
                end
            end
        end
    end

    int  waited;
    logic fired;

    initial begin
        ARESETN = 1'b0;
        M_AXIS_tready = 1'b0;
        tv = '0;
        s_last = '0;
        for (int i = 0; i < N; i++) begin
            s_data[i] = '0; s_keep[i] = '0; fid[i] = 0; m_cnt[i] = '0;
            rand_cfg(i);
        end
        cfg_ps[2] = 14'd256;

        // Reset, then check reset values from the first post-reset cycle
        do_rst = 1'b1;
        step();
        step();
        mon_en = 1'b1;
        do_rst = 1'b0;

        // Single source 2 with 3-beat frames, sink always ready
        run(30, 4'b0100, 100, 3, 3, 100, 100, 0);
        // All sources, 1-beat frames back to back
        run(60, 4'b1111, 100, 1, 1, 100, 100, 0);
        // Backpressure on the sink
        run(200, 4'b1111, 80, 1, 4, 100, 50, 0);

        // Granted source's destination changes mid-frame: header must hold
        run(8, 4'b0000, 0, 1, 1, 100, 100, 0);
        cfg_da[1] = 48'h0A0B0C0D0E0F;
        gen_mask = 4'b0010; gen_pct = 100; len_min = 4; len_max = 4;
        waited = 0;
        while (!(m_busy && m_src == 1) && waited < 30) begin
            step();
            waited++;
        end
        gen_pct = 0;
        cfg_da[1] = 48'hFFFFFFFFFFFF;
        step();
        step();
        check("dst_hold", 64'(Destination_Address), 64'(48'h0A0B0C0D0E0F));
        run(20, 4'b0000, 0, 1, 1, 100, 100, 0);

        // Reset pulse in the middle of a 4-beat frame
        gen_mask = 4'b1111; gen_pct = 100; len_min = 4; len_max = 4;
        vld_pct = 100; rdy_pct = 100; cfg_pct = 0;
        fired = 1'b0;
        for (int c = 0; c < 100 && !fired; c++) begin
            if (m_busy && m_left == 3) begin
                do_rst = 1'b1;
                fired = 1'b1;
            end
            step();
            do_rst = 1'b0;
        end
        check("reset_pulse_fired", 64'(fired), 64'(1));
        run(40, 4'b1111, 100, 1, 1, 100, 100, 0);

        // Mixed random traffic with config churn
        run(1500, 4'b1111, 50, 1, 5, 70, 70, 10);

        // Drain: no new frames, sink ready, bounded wait
        gen_mask = '0; gen_pct = 0; vld_pct = 100; rdy_pct = 100; cfg_pct = 0;
        waited = 0;
        while ((exp_q.size() > 0 || m_busy || src_q[0].size() > 0 || src_q[1].size() > 0 ||
                src_q[2].size() > 0 || src_q[3].size() > 0) && waited < 500) begin
            step();
            waited++;
        end
        step();
        check("drain_expected_left", 64'(exp_q.size()), 64'(0));
        check("drain_model_idle", 64'(m_busy), 64'(0));

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
